// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one SRAM controller between two requesters.
//            - Port 0 is the MEM-stage data port.
//            - Port 1 is a secondary master (fetch or debug loader).
//            One transaction is held in flight at a time. The block drives
//            the controller's R/W enables, address and write data, then waits
//            for the controller's ready. When the access finishes it returns
//            a registered read result and a one-cycle completion ready, both
//            to the granted port only.
// Ports    : clk, rst (asynchronous, active-high)
//            pX_r_en/pX_w_en/pX_addr/pX_wdata -> requester X command (held
//                                                until pX_ready)
//            pX_ready/pX_rdata                <- requester X completion/data
//            sram_r_en/w_en/addr/wdata        -> SRAM controller command
//            sram_ready/sram_rdata            <- SRAM controller response
//            busy, grant_id, timeout_err      -> status
// Config   : ARB_FIXED_PRIO_EN defined -> port 0 always wins ties
//            (default: round-robin tie-break).
// Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int WDATA_W     = 32,
  parameter int RDATA_W     = 64,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_r_en,
  input  logic               p0_w_en,
  input  logic [ADDR_W-1:0]  p0_addr,
  input  logic [WDATA_W-1:0] p0_wdata,
  output logic               p0_ready,
  output logic [RDATA_W-1:0] p0_rdata,
  input  logic               p1_r_en,
  input  logic               p1_w_en,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [WDATA_W-1:0] p1_wdata,
  output logic               p1_ready,
  output logic [RDATA_W-1:0] p1_rdata,
  output logic               sram_r_en,
  output logic               sram_w_en,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [WDATA_W-1:0] sram_wdata,
  input  logic               sram_ready,
  input  logic [RDATA_W-1:0] sram_rdata,
  output logic               busy,
  output logic               grant_id,
  output logic               timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WDATA_W-1:0] wdata_q, wdata_d;
  logic               grant_q, grant_d;
  logic               rr_last_q, rr_last_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               terr_q, terr_d;
  logic [RDATA_W-1:0] rd0_q, rd0_d;
  logic [RDATA_W-1:0] rd1_q, rd1_d;

  logic req0, req1;
  logic winner;

  assign req0 = p0_r_en | p0_w_en;
  assign req1 = p1_r_en | p1_w_en;

  // Winner is only meaningful when at least one request is present.
  always_comb begin
    winner = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    winner = ~req0;
`else
    // On a tie, the port that did not own the last transaction wins.
    winner = (req0 & req1) ? ~rr_last_q : req1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    tmo_d     = tmo_q;
    terr_d    = terr_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          // If r_en and w_en are both high, the access is a write.
          op_wr_d = winner ? p1_w_en  : p0_w_en;
          addr_d  = winner ? p1_addr  : p0_addr;
          wdata_d = winner ? p1_wdata : p0_wdata;
          grant_d = winner;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sram_ready) begin
          if (!op_wr_q) begin
            if (grant_q) rd1_d = sram_rdata;
            else         rd0_d = sram_rdata;
          end
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        // The enables are low for this cycle, so the controller's own counter can clear.
        rr_last_d = grant_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      tmo_q     <= '0;
      terr_q    <= 1'b0;
      rd0_q     <= '0;
      rd1_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      tmo_q     <= tmo_d;
      terr_q    <= terr_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
    end
  end

  // The enables are decoded from the state register. This drops them as
  // soon as the asynchronous reset arrives.
  assign sram_r_en   = (state_q == S_ISSUE) & ~op_wr_q;
  assign sram_w_en   = (state_q == S_ISSUE) &  op_wr_q;
  assign sram_addr   = addr_q;
  assign sram_wdata  = wdata_q;

  // A port with no request is never stalled.
  assign p0_ready    = ~req0 | ((state_q == S_DONE) & ~grant_q);
  assign p1_ready    = ~req1 | ((state_q == S_DONE) &  grant_q);
  assign p0_rdata    = rd0_q;
  assign p1_rdata    = rd1_q;

  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_q;
  assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Directed testbench for sram_port_arbiter. It includes a small
//            SRAM controller model that raises ready in the 6th cycle of an
//            enabled access.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_r_en = 0, p0_w_en = 0, p1_r_en = 0, p1_w_en = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ready, p1_ready;
  logic [63:0] p0_rdata, p1_rdata;
  logic        sram_r_en, sram_w_en, sram_ready;
  logic [31:0] sram_addr, sram_wdata;
  logic [63:0] sram_rdata;
  logic        busy, grant_id, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // SRAM controller model
  logic [4:0]  m_cnt = '0;
  logic        m_stuck = 1'b0;
  logic        m_fixed = 1'b1;
  logic [63:0] m_val = 64'hDEAD_BEEF_0123_4567;

  always @(posedge clk) begin
    if (sram_r_en | sram_w_en) m_cnt <= m_cnt + 5'd1;
    else                       m_cnt <= '0;
  end
  assign sram_ready = (sram_r_en | sram_w_en) && !m_stuck && (m_cnt == 5'd5);
  assign sram_rdata = m_fixed ? m_val : {32'hCAFE_F00D, sram_addr};

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_r_en(p0_r_en), .p0_w_en(p0_w_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rdata(p0_rdata),
    .p1_r_en(p1_r_en), .p1_w_en(p1_w_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  // Drives one request from a negedge and holds it until that port's ready is seen.
  task automatic run_txn(input bit port, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int maxc,
                         output int en_cyc, output int lat, output int bad, output int other_nr);
    en_cyc = 0; lat = 0; bad = 0; other_nr = 0;
    if (port) begin p1_r_en = !wr; p1_w_en = wr; p1_addr = a; p1_wdata = d; end
    else      begin p0_r_en = !wr; p0_w_en = wr; p0_addr = a; p0_wdata = d; end
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (sram_r_en | sram_w_en) begin
        en_cyc++;
        if (sram_addr !== a || sram_w_en !== wr || sram_r_en !== !wr || (wr && sram_wdata !== d))
          bad++;
      end
      if ((port ? p0_ready : p1_ready) !== 1'b1) other_nr++;
      if ((port ? p1_ready : p0_ready) === 1'b1) begin lat = i; break; end
    end
    p0_r_en = 0; p0_w_en = 0; p1_r_en = 0; p1_w_en = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({sram_r_en, sram_w_en, busy, grant_id, timeout_err} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {sram_r_en, sram_w_en, busy, grant_id, timeout_err}); end
    n_cmp++; if (sram_addr !== 32'h0 || sram_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_sram_bus: got addr %h wdata %h want 0 0", sram_addr, sram_wdata); end
    n_cmp++; if (p0_rdata !== 64'h0 || p1_rdata !== 64'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h %h want 0 0", p0_rdata, p1_rdata); end
    n_cmp++; if (p0_ready !== 1'b1 || p1_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b%b want 11", p0_ready, p1_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_p0_read;
    int en, lat, bad, onr;
    m_fixed = 1'b1;
    run_txn(1'b0, 1'b0, 32'h400, 32'h0, 20, en, lat, bad, onr);
    n_cmp++; if (en !== 6) begin n_err++; $display("FAIL t1_ren_cycles: got %0d want 6", en); end
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL t1_latency: got %0d want 7", lat); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL t1_sram_cmd: got %0d bad cycles want 0", bad); end
    n_cmp++; if (p0_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      n_err++; $display("FAIL t1_rdata: got %h want deadbeef01234567", p0_rdata); end
    n_cmp++; if (busy !== 1'b0 || grant_id !== 1'b0) begin
      n_err++; $display("FAIL t1_status: got busy %b grant %b want 0 0", busy, grant_id); end
  endtask

  task automatic test_p1_write;
    int en, lat, bad, onr;
    run_txn(1'b1, 1'b1, 32'h408, 32'h1234_5678, 20, en, lat, bad, onr);
    n_cmp++; if (en !== 6) begin n_err++; $display("FAIL t2_wen_cycles: got %0d want 6", en); end
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL t2_latency: got %0d want 7", lat); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL t2_sram_cmd: got %0d bad cycles want 0", bad); end
    n_cmp++; if (onr !== 0) begin n_err++; $display("FAIL t2_p0_ready: got %0d low cycles want 0", onr); end
    n_cmp++; if (p1_rdata !== 64'h0 || p0_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      n_err++; $display("FAIL t2_rdata_untouched: got %h %h want 0 deadbeef01234567", p1_rdata, p0_rdata); end
    n_cmp++; if (grant_id !== 1'b1) begin n_err++; $display("FAIL t2_grant: got %b want 1", grant_id); end
  endtask

  task automatic test_round_robin;
    int  pulses;
    int  idx[4];
    bit  gid[4];
    bit  exp_id;
    m_fixed = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin idx[k] = -1; gid[k] = 1'b0; end
    p0_r_en = 1; p0_addr = 32'hA00; p1_r_en = 1; p1_addr = 32'hB00;
    for (int i = 1; i <= 40 && pulses < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (p0_ready === 1'b1 && p1_ready === 1'b1) begin
        n_err++; $display("FAIL t3_both_ready: got 11 at cycle %0d want at most one", i); end
      if (p0_ready === 1'b1) begin
        idx[pulses] = i; gid[pulses] = 1'b0; pulses++;
        n_cmp++; if (p0_rdata !== {32'hCAFE_F00D, 32'hA00}) begin
          n_err++; $display("FAIL t3_p0_rdata: got %h want cafef00d00000a00", p0_rdata); end
      end else if (p1_ready === 1'b1) begin
        idx[pulses] = i; gid[pulses] = 1'b1; pulses++;
        n_cmp++; if (p1_rdata !== {32'hCAFE_F00D, 32'hB00}) begin
          n_err++; $display("FAIL t3_p1_rdata: got %h want cafef00d00000b00", p1_rdata); end
      end
    end
    p0_r_en = 0; p1_r_en = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (pulses !== 4) begin n_err++; $display("FAIL t3_pulses: got %0d want 4", pulses); end
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (k % 2 == 1);
`endif
      n_cmp++; if (idx[k] !== 7 + 8 * k || gid[k] !== exp_id) begin
        n_err++; $display("FAIL t3_grant%0d: got cycle %0d port %0d want cycle %0d port %0d",
                          k, idx[k], gid[k], 7 + 8 * k, exp_id); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t3_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_late_request;
    int t0, t1, bad;
    t0 = -1; t1 = -1; bad = 0;
    p0_r_en = 1; p0_addr = 32'h500;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sram_r_en === 1'b1) begin
        if ((grant_id == 1'b0) ? (sram_addr !== 32'h500) : (sram_addr !== 32'h600)) bad++;
      end
      if (i == 4) begin
        n_cmp++; if (sram_addr !== 32'h500 || sram_r_en !== 1'b1) begin
          n_err++; $display("FAIL t4_latched_addr: got %h en %b want 00000500 1", sram_addr, sram_r_en); end
      end
      if (p0_r_en && p0_ready) begin t0 = i; p0_r_en = 0; end
      if (p1_r_en && p1_ready) begin t1 = i; p1_r_en = 0; end
      if (i == 1) begin p1_r_en = 1; p1_addr = 32'h600; end
      if (i == 3) p0_addr = 32'hFFF0;
    end
    n_cmp++; if (t0 !== 7) begin n_err++; $display("FAIL t4_p0_done: got %0d want 7", t0); end
    n_cmp++; if (t1 !== 15) begin n_err++; $display("FAIL t4_p1_done: got %0d want 15", t1); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL t4_sram_addr: got %0d bad cycles want 0", bad); end
    n_cmp++; if (p0_rdata !== {32'hCAFE_F00D, 32'h500} || p1_rdata !== {32'hCAFE_F00D, 32'h600}) begin
      n_err++; $display("FAIL t4_rdata: got %h %h want cafef00d00000500 cafef00d00000600", p0_rdata, p1_rdata); end
  endtask

  task automatic test_timeout;
    int en, lat, bad, onr;
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL t5_pre_err: got %b want 0", timeout_err); end
    m_stuck = 1'b1;
    run_txn(1'b0, 1'b0, 32'h700, 32'h0, 30, en, lat, bad, onr);
    m_stuck = 1'b0;
    n_cmp++; if (en !== 15) begin n_err++; $display("FAIL t5_issue_cycles: got %0d want 15", en); end
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL t5_latency: got %0d want 16", lat); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL t5_err_set: got %b want 1", timeout_err); end
    n_cmp++; if (p0_rdata !== {32'hCAFE_F00D, 32'h500}) begin
      n_err++; $display("FAIL t5_rdata_kept: got %h want cafef00d00000500", p0_rdata); end
    run_txn(1'b1, 1'b1, 32'h708, 32'h0000_55AA, 20, en, lat, bad, onr);
    n_cmp++; if (lat !== 7 || timeout_err !== 1'b1) begin
      n_err++; $display("FAIL t5_sticky: got lat %0d err %b want 7 1", lat, timeout_err); end
  endtask

  task automatic test_async_reset;
    int en, lat, bad, onr;
    p0_r_en = 1; p0_addr = 32'h800;
    repeat (3) @(negedge clk);
    n_cmp++; if (sram_r_en !== 1'b1) begin n_err++; $display("FAIL t6_in_issue: got %b want 1", sram_r_en); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({sram_r_en, sram_w_en, busy, grant_id, timeout_err} !== 5'b0 || sram_addr !== 32'h0) begin
      n_err++; $display("FAIL t6_async_clear: got %b addr %h want 00000 0",
                        {sram_r_en, sram_w_en, busy, grant_id, timeout_err}, sram_addr); end
    n_cmp++; if (p0_rdata !== 64'h0 || p1_rdata !== 64'h0) begin
      n_err++; $display("FAIL t6_rdata_clear: got %h %h want 0 0", p0_rdata, p1_rdata); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (p0_ready !== 1'b0 || sram_r_en !== 1'b0) begin
        n_err++; $display("FAIL t6_no_pulse: got ready %b en %b want 0 0", p0_ready, sram_r_en); end
    end
    p0_r_en = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(1'b1, 1'b0, 32'h900, 32'h0, 20, en, lat, bad, onr);
    n_cmp++; if (lat !== 7 || en !== 6 || bad !== 0) begin
      n_err++; $display("FAIL t6_after_reset: got lat %0d en %0d bad %0d want 7 6 0", lat, en, bad); end
    n_cmp++; if (p1_rdata !== {32'hCAFE_F00D, 32'h900} || p0_rdata !== 64'h0) begin
      n_err++; $display("FAIL t6_rdata: got %h %h want cafef00d00000900 0", p1_rdata, p0_rdata); end
  endtask

  initial begin
    test_reset();
    test_p0_read();
    test_p1_write();
    test_round_robin();
    test_late_request();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion within 100000 time units, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
